hi_fanout_load_sched: RTL

- Sequencer for one high-fanout register: a single driver flop (net0) fanning out to NUM_BANKS load banks of LOADS_PER_BANK flops each.
- Accepts a new value by valid/ready handshake and updates the driver register.
- Waits SETTLE_CYCLES so the buffered or repeated net can propagate, then pulses per-bank load enables one bank at a time, with GAP_CYCLES between banks, to limit simultaneous switching.
- Sits between upstream control and the replicated load-bank hierarchy.

---
 rtl/hi_fanout_sched_pkg.sv | 15 +
 rtl/lowest_set_onehot.sv | 15 +
 rtl/hi_fanout_load_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/hi_fanout_sched_pkg.sv
// rtl/hi_fanout_sched_pkg.sv - shared state encoding and limits for the high-fanout load sequencer
package hi_fanout_sched_pkg;

   localparam int CNT_W     = 4;
   localparam int MAX_BANKS = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      LOAD   = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/lowest_set_onehot.sv
// rtl/lowest_set_onehot.sv - one-hot of the lowest set bit of a vector (zero in, zero out)
module lowest_set_onehot #(
   parameter int NUM_BANKS = 2
) (
   input  logic [NUM_BANKS-1:0] i_vec,
   output logic [NUM_BANKS-1:0] o_onehot
);

   logic [NUM_BANKS-1:0] w_one;

   assign w_one    = NUM_BANKS'(1);
   // Two's-complement trick: x & -x isolates the lowest set bit.
   assign o_onehot = i_vec & (~i_vec + w_one);

endmodule

// File: rtl/hi_fanout_load_sched.sv
// rtl/hi_fanout_load_sched.sv - drives one high-fanout net and staggers per-bank load enables
module hi_fanout_load_sched
   import hi_fanout_sched_pkg::*;
#(
   parameter int WIDTH          = 1,
   parameter int NUM_BANKS      = 2,
   parameter int LOADS_PER_BANK = 35,
   parameter int SETTLE_CYCLES  = 1,
   parameter int GAP_CYCLES     = 0
) (
   input  logic                 clk1,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [NUM_BANKS-1:0] bank_mask,
   output logic [WIDTH-1:0]     net0,
   output logic [NUM_BANKS-1:0] bank_en,
   output logic                 busy,
   output logic                 done
);

   if (NUM_BANKS < 1 || NUM_BANKS > MAX_BANKS || LOADS_PER_BANK < 1 ||
       SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15 || GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_check
      $error("hi_fanout_load_sched: parameter out of range");
   end

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_net0;
   logic [WIDTH-1:0]     w_net0_nxt;
   logic [NUM_BANKS-1:0] r_mask;
   logic [NUM_BANKS-1:0] w_mask_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [NUM_BANKS-1:0] w_lowest;
   logic [NUM_BANKS-1:0] w_mask_rem;

   lowest_set_onehot #(.NUM_BANKS(NUM_BANKS)) u_pick (
      .i_vec    (r_mask),
      .o_onehot (w_lowest)
   );

   assign w_mask_rem = r_mask & ~w_lowest;

   always_ff @(posedge clk1) begin
      if (rst) begin
         r_state <= IDLE;
         r_net0  <= '0;
         r_mask  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_net0  <= w_net0_nxt;
         r_mask  <= w_mask_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_net0_nxt  = r_net0;
      w_mask_nxt  = r_mask;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_net0_nxt = in_data;
               w_mask_nxt = bank_mask;
               w_cnt_nxt  = CNT_W'(SETTLE_CYCLES);
               if (SETTLE_CYCLES > 0)  w_state_nxt = SETTLE;
               else if (|bank_mask)    w_state_nxt = LOAD;
               else                    w_state_nxt = DONE;
            end
         end
         SETTLE: begin
            // Counter holds the remaining cycles including the current one.
            if (r_cnt <= CNT_W'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (|r_mask) ? LOAD : DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         LOAD: begin
            w_mask_nxt = w_mask_rem;
            if (w_mask_rem == '0) begin
               w_state_nxt = DONE;
            end else if (GAP_CYCLES > 0) begin
               w_state_nxt = GAP;
               w_cnt_nxt   = CNT_W'(GAP_CYCLES);
            end
         end
         GAP: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = LOAD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign net0     = r_net0;
   assign bank_en  = (r_state == LOAD) ? w_lowest : '0;
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign in_ready = (r_state == IDLE);

endmodule
